// File: rtl/tpu_rsqrt_pkg.sv
// Shared types and latency helper for the tpu_rsqrt_unit and its requester-side logic.
package tpu_rsqrt_pkg;

    localparam int RSQRT_DEFAULT_ITERS = 2;

    // Pipe depth of the unit: fixed front/back stages plus three per Newton iteration.
    function automatic int RSQRT_LATENCY(input int iters);
        return 3 + 3 * iters;
    endfunction

    typedef struct packed {
        logic        special;
        logic [15:0] data;
    } rsqrt_rsp_t;

endpackage

// File: rtl/tpu_rsqrt_resp_fifo.sv
// First-word-fall-through response buffer; push and pop may coincide at any occupancy.
module tpu_rsqrt_resp_fifo
    import tpu_rsqrt_pkg::*;
#(
    parameter  int WIDTH = 17,
    parameter  int DEPTH = 4,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_pop_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [CW-1:0]    o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_pop;
    logic             w_do_push;

    assign o_empty    = (r_count == '0);
    assign o_full     = (r_count == CW'(DEPTH));
    assign o_count    = r_count;
    assign o_pop_data = r_mem[r_rd_ptr];
    assign w_do_pop   = i_pop & ~o_empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_do_push  = i_push & (~o_full | w_do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr <= (r_wr_ptr == AW'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= (r_rd_ptr == AW'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
            end
            r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
        end
    end

endmodule

// File: rtl/tpu_rsqrt_arbiter.sv
// Round-robin, credit-gated sharing of one pipelined rsqrt unit; a latency-matched
// tag pipe steers each result into its requester's response FIFO.
module tpu_rsqrt_arbiter
    import tpu_rsqrt_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int DATA_WIDTH     = 16,
    parameter int NUM_ITERATIONS = RSQRT_DEFAULT_ITERS,
    parameter int RESP_DEPTH     = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [NUM_REQ*DATA_WIDTH-1:0] rsp_data,
    output logic [NUM_REQ-1:0]            rsp_special,
    input  logic [NUM_REQ-1:0]            rsp_ready,
    output logic                          rs_enable,
    output logic [DATA_WIDTH-1:0]         rs_data_in,
    output logic                          rs_data_valid,
    input  logic [DATA_WIDTH-1:0]         rs_data_out,
    input  logic                          rs_data_out_valid,
    input  logic                          rs_special,
    output logic                          err_latency,
    output logic [31:0]                   grant_count,
    output logic [31:0]                   credit_stall
);

    localparam int L   = RSQRT_LATENCY(NUM_ITERATIONS);
    localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW  = $clog2(RESP_DEPTH + 1);
    localparam int FW  = DATA_WIDTH + 1;

    logic                 r_rs_enable;
    logic [IDW-1:0]       r_rr_ptr;
    logic [CW-1:0]        r_credit [NUM_REQ];
    logic [L-1:0]         r_tag_v;
    logic [IDW-1:0]       r_tag_id [L];
    logic                 r_err;
    logic [31:0]          r_grant_count;
    logic [31:0]          r_credit_stall;

    logic [NUM_REQ-1:0]   w_elig, w_grant, w_push, w_pop, w_rel, w_full, w_empty;
    logic [IDW-1:0]       w_winner;
    logic [IDW-1:0]       w_idx;
    logic                 w_any_grant;
    logic                 w_tail_v;
    logic [IDW-1:0]       w_tail_id;
    logic                 w_ovf;
    logic [CW-1:0]        w_count [NUM_REQ];
    logic [FW-1:0]        w_fifo_out [NUM_REQ];

    always_comb begin
        w_elig = '0;
        for (int i = 0; i < NUM_REQ; i++)
            w_elig[i] = req_valid[i] & (r_credit[i] < CW'(RESP_DEPTH)) & r_rs_enable;
    end

    // Scan backwards so the eligible requester closest to rr_ptr is the last one written.
    always_comb begin
        w_grant  = '0;
        w_winner = '0;
        w_idx    = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_idx = IDW'((int'(r_rr_ptr) + k) % NUM_REQ);
            if (w_elig[w_idx]) begin
                w_grant        = '0;
                w_grant[w_idx] = 1'b1;
                w_winner       = w_idx;
            end
        end
    end

    assign w_any_grant   = |w_grant;
    assign req_ready     = w_grant;
    assign rs_data_valid = w_any_grant;
    assign rs_data_in    = w_any_grant ? req_data[int'(w_winner)*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign rs_enable     = r_rs_enable;
    assign err_latency   = r_err;
    assign grant_count   = r_grant_count;
    assign credit_stall  = r_credit_stall;

    assign w_tail_v  = r_tag_v[L-1];
    assign w_tail_id = r_tag_id[L-1];

    always_comb begin
        w_push = '0;
        w_rel  = '0;
        w_pop  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_push[i] = w_tail_v & rs_data_out_valid & (w_tail_id == IDW'(i));
            w_rel[i]  = w_tail_v & ~rs_data_out_valid & (w_tail_id == IDW'(i));
            w_pop[i]  = ~w_empty[i] & rsp_ready[i];
        end
    end

    assign w_ovf = |(w_push & w_full & ~w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rs_enable    <= 1'b0;
            r_rr_ptr       <= '0;
            r_tag_v        <= '0;
            r_err          <= 1'b0;
            r_grant_count  <= '0;
            r_credit_stall <= '0;
            for (int i = 0; i < NUM_REQ; i++) r_credit[i] <= '0;
            for (int s = 0; s < L; s++) r_tag_id[s] <= '0;
        end else begin
            r_rs_enable <= 1'b1;
            if (w_any_grant)
                r_rr_ptr <= (int'(w_winner) == NUM_REQ - 1) ? '0 : w_winner + 1'b1;
            r_tag_v     <= {r_tag_v[L-2:0], w_any_grant};
            r_tag_id[0] <= w_winner;
            for (int s = 1; s < L; s++) r_tag_id[s] <= r_tag_id[s-1];
            // A pop and a tag release for the same requester can coincide.
            for (int i = 0; i < NUM_REQ; i++)
                r_credit[i] <= r_credit[i] + CW'(w_grant[i]) - CW'(w_pop[i]) - CW'(w_rel[i]);
            r_err <= r_err | (w_tail_v ^ rs_data_out_valid) | w_ovf;
            if (w_any_grant)
                r_grant_count <= r_grant_count + 32'd1;
            if ((|req_valid) & r_rs_enable & ~w_any_grant)
                r_credit_stall <= r_credit_stall + 32'd1;
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_rsp
        tpu_rsqrt_resp_fifo #(
            .WIDTH (FW),
            .DEPTH (RESP_DEPTH)
        ) u_fifo (
            .clk         (clk),
            .rst_n       (rst_n),
            .i_push      (w_push[g]),
            .i_push_data ({rs_special, rs_data_out}),
            .i_pop       (w_pop[g]),
            .o_pop_data  (w_fifo_out[g]),
            .o_full      (w_full[g]),
            .o_empty     (w_empty[g]),
            .o_count     (w_count[g])
        );

        assign rsp_valid[g]                             = ~w_empty[g];
        assign rsp_data[g*DATA_WIDTH +: DATA_WIDTH]     = w_fifo_out[g][DATA_WIDTH-1:0];
        assign rsp_special[g]                           = w_fifo_out[g][DATA_WIDTH];

        // Buffered entries are always a subset of the outstanding credits.
        a_count_le_credit : assert property (@(posedge clk) disable iff (!rst_n)
            w_count[g] <= r_credit[g]);
    end

endmodule

// File: tb/tb_tpu_rsqrt_arbiter.sv
// Directed bench: a behavioural rsqrt unit with fixed latency drives the arbiter's unit port.
module tb_tpu_rsqrt_arbiter;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int L  = 9;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N-1:0]      req_valid;
    logic [N*DW-1:0]   req_data;
    logic [N-1:0]      req_ready;
    logic [N-1:0]      rsp_valid;
    logic [N*DW-1:0]   rsp_data;
    logic [N-1:0]      rsp_special;
    logic [N-1:0]      rsp_ready;
    logic              rs_enable;
    logic [DW-1:0]     rs_data_in;
    logic              rs_data_valid;
    logic [DW-1:0]     rs_data_out;
    logic              rs_data_out_valid;
    logic              rs_special;
    logic              err_latency;
    logic [31:0]       grant_count;
    logic [31:0]       credit_stall;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    tpu_rsqrt_arbiter dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .req_valid         (req_valid),
        .req_data          (req_data),
        .req_ready         (req_ready),
        .rsp_valid         (rsp_valid),
        .rsp_data          (rsp_data),
        .rsp_special       (rsp_special),
        .rsp_ready         (rsp_ready),
        .rs_enable         (rs_enable),
        .rs_data_in        (rs_data_in),
        .rs_data_valid     (rs_data_valid),
        .rs_data_out       (rs_data_out),
        .rs_data_out_valid (rs_data_out_valid),
        .rs_special        (rs_special),
        .err_latency       (err_latency),
        .grant_count       (grant_count),
        .credit_stall      (credit_stall)
    );

    // Stand-in unit: L-cycle pipe, output = x ^ 0x5A5A, or 0x7FFF flagged special for x == 0.
    logic [L-1:0]  u_v;
    logic [DW-1:0] u_d [L];
    logic          u_drop;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            u_v <= '0;
            for (int i = 0; i < L; i++) u_d[i] <= '0;
        end else begin
            u_v    <= {u_v[L-2:0], rs_data_valid & rs_enable};
            u_d[0] <= rs_data_in;
            for (int i = 1; i < L; i++) u_d[i] <= u_d[i-1];
        end
    end

    assign rs_data_out_valid = u_v[L-1] & ~u_drop;
    assign rs_data_out       = (u_d[L-1] == 16'h0000) ? 16'h7FFF : (u_d[L-1] ^ 16'h5A5A);
    assign rs_special        = u_v[L-1] & (u_d[L-1] == 16'h0000);

    function automatic logic [DW-1:0] unit_f(input logic [DW-1:0] x);
        return (x == 16'h0000) ? 16'h7FFF : (x ^ 16'h5A5A);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [DW-1:0] exq [N][$];
    logic [N-1:0]  eg;
    int            g;
    int            pops;

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        rsp_ready = '1;
        u_drop    = 1'b0;
        pops      = 0;

        // Reset state
        repeat (3) step();
        chk("rst_rs_enable", rs_enable, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_grant_count", grant_count, 0);
        chk("rst_err", err_latency, 0);
        rst_n = 1'b1;
        #1;
        chk("rs_enable_still_low", rs_enable, 0);
        step();
        chk("rs_enable_high", rs_enable, 1);

        // Single request, latency L
        req_valid = 4'b0001;
        req_data[15:0] = 16'h0100;
        #1;
        chk("single_ready", req_ready, 4'b0001);
        chk("single_rs_data_in", rs_data_in, 16'h0100);
        chk("single_rs_valid", rs_data_valid, 1);
        step();
        req_valid = '0;
        #1;
        chk("single_rs_valid_off", rs_data_valid, 0);
        repeat (8) step();
        chk("single_not_yet", rsp_valid, 0);
        step();
        chk("single_rsp_valid", rsp_valid, 4'b0001);
        chk("single_rsp_data", rsp_data[15:0], 16'h5B5A);
        chk("single_rsp_special", rsp_special, 0);
        chk("single_grant_count", grant_count, 1);
        step();

        // Round robin, rr_ptr = 1 after the single grant to 0
        for (int n = 0; n < 20; n++) begin
            if (n < 8) begin
                req_valid = '1;
                for (int i = 0; i < N; i++) req_data[i*DW +: DW] = 16'(16'h0100 * (i + 1) + n);
            end else begin
                req_valid = '0;
            end
            #1;
            if (n < 8) begin
                g  = (1 + n) % N;
                eg = 4'(1 << g);
                chk("rr_grant", req_ready, eg);
                exq[g].push_back(unit_f(req_data[g*DW +: DW]));
            end
            for (int i = 0; i < N; i++) begin
                if (exq[i].size() == 0) begin
                    chk("rr_rsp_unexpected", rsp_valid[i], 0);
                end else if (rsp_valid[i]) begin
                    chk("rr_rsp_data", rsp_data[i*DW +: DW], exq[i].pop_front());
                    pops++;
                end
            end
            step();
        end
        chk("rr_pops", pops, 8);
        chk("rr_credit_stall", credit_stall, 0);
        chk("rr_err", err_latency, 0);
        chk("rr_grant_count", grant_count, 9);

        // Credit exhaustion on requester 2
        rsp_ready = 4'b1011;
        req_valid = 4'b0100;
        req_data[2*DW +: DW] = 16'h0200;
        for (int n = 0; n < 4; n++) begin
            #1;
            chk("credit_grant", req_ready, 4'b0100);
            step();
        end
        #1;
        chk("credit_block", req_ready, 0);
        repeat (14) step();
        chk("credit_stall_14", credit_stall, 14);
        chk("credit_fifo_valid", rsp_valid[2], 1);
        chk("credit_fifo_data", rsp_data[2*DW +: DW], 16'h585A);
        rsp_ready[2] = 1'b1;
        #1;
        chk("credit_block_pop_cycle", req_ready, 0);
        step();
        rsp_ready[2] = 1'b0;
        #1;
        chk("credit_one_more", req_ready, 4'b0100);
        step();
        #1;
        chk("credit_block_again", req_ready, 0);
        step();
        req_valid = '0;
        rsp_ready = '1;
        repeat (15) step();
        chk("credit_stall_16", credit_stall, 16);
        chk("credit_drained", rsp_valid, 0);
        chk("credit_grant_count", grant_count, 14);

        // Special case from requester 1
        req_valid = 4'b0010;
        req_data[DW +: DW] = 16'h0000;
        #1;
        chk("special_ready", req_ready, 4'b0010);
        step();
        req_valid = '0;
        repeat (8) step();
        chk("special_not_yet", rsp_valid, 0);
        step();
        chk("special_valid", rsp_valid, 4'b0010);
        chk("special_flag", rsp_special, 4'b0010);
        chk("special_data", rsp_data[DW +: DW], 16'h7FFF);
        step();

        // Latency error: first of four results to requester 0 goes missing
        rsp_ready = 4'b1110;
        req_valid = 4'b0001;
        req_data[15:0] = 16'h0100;
        for (int n = 0; n < 4; n++) begin
            #1;
            chk("err_grant", req_ready, 4'b0001);
            step();
        end
        req_valid = '0;
        repeat (5) step();
        u_drop = 1'b1;
        #1;
        chk("err_before", err_latency, 0);
        step();
        u_drop = 1'b0;
        #1;
        chk("err_set", err_latency, 1);
        chk("err_nothing_pushed", rsp_valid[0], 0);
        repeat (4) step();
        chk("err_rest_arrived", rsp_valid, 4'b0001);
        chk("err_sticky", err_latency, 1);
        req_valid = 4'b0001;
        #1;
        chk("err_credit_restored", req_ready, 4'b0001);
        step();
        req_valid = '0;
        rsp_ready = '1;
        repeat (15) step();
        chk("err_drained", rsp_valid, 0);
        chk("err_still_sticky", err_latency, 1);

        // Reset with operations in flight and FIFOs partly full
        rsp_ready = '0;
        req_valid = '1;
        for (int i = 0; i < N; i++) req_data[i*DW +: DW] = 16'(16'h0300 + i);
        repeat (6) step();
        req_valid = '0;
        repeat (6) step();
        chk("pre_reset_rsp", rsp_valid, 4'b1110);
        rst_n = 1'b0;
        #1;
        chk("midrst_rsp_valid", rsp_valid, 0);
        chk("midrst_grant_count", grant_count, 0);
        chk("midrst_stall", credit_stall, 0);
        chk("midrst_err", err_latency, 0);
        chk("midrst_rs_enable", rs_enable, 0);
        rsp_ready = '1;
        repeat (2) step();
        rst_n = 1'b1;
        step();
        req_valid = 4'b1000;
        req_data[3*DW +: DW] = 16'h0040;
        #1;
        chk("post_rst_ready", req_ready, 4'b1000);
        step();
        req_valid = '0;
        repeat (8) step();
        chk("post_rst_not_yet", rsp_valid, 0);
        chk("post_rst_err", err_latency, 0);
        step();
        chk("post_rst_valid", rsp_valid, 4'b1000);
        chk("post_rst_data", rsp_data[3*DW +: DW], 16'h5A1A);
        chk("post_rst_grant_count", grant_count, 1);
        repeat (3) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tpu_rsqrt_arbiter.md
Name: tpu_rsqrt_arbiter

Overview:
Shares one pipelined tpu_rsqrt_unit among NUM_REQ independent requesters, such as MD force lanes and the layer-norm engine. Requests are granted round-robin and sent to the unit. A latency-matched tag pipeline records which requester owns each in-flight operation. Each result is steered into that requester's response FIFO. The unit has no output backpressure, so grants are credit-gated: a requester is granted only if its response FIFO is guaranteed a free slot.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_WIDTH, 16, operand/result width (Q8.8 in, Q1.15 out)
NUM_ITERATIONS, 2, Newton iterations of the attached unit; sets the pipe latency
RESP_DEPTH, 4, per-requester response FIFO depth; equals the per-requester credit limit

Ports:
clk  in  1  clock
rst_n  in  1  async active-low reset
req_valid  in  NUM_REQ  request valid, one bit per requester
req_data  in  NUM_REQ x DATA_WIDTH  Q8.8 operand per requester
req_ready  out  NUM_REQ  one-hot grant; handshake = valid & ready
rsp_valid  out  NUM_REQ  response available
rsp_data  out  NUM_REQ x DATA_WIDTH  Q1.15 result
rsp_special  out  NUM_REQ  result is a special case
rsp_ready  in  NUM_REQ  response consumed
rs_enable  out  1  drives unit enable
rs_data_in  out  DATA_WIDTH  to unit data_in
rs_data_valid  out  1  to unit data_valid
rs_data_out  in  DATA_WIDTH  from unit
rs_data_out_valid  in  1  from unit
rs_special  in  1  from unit special_case
err_latency  out  1  sticky latency-mismatch flag
grant_count  out  32  total operations issued
credit_stall  out  32  cycles lost to credit exhaustion

Behaviour:
- Reset clears all of the following to 0: outputs, rr_ptr, credit counters, tag pipe, FIFOs, err_latency, counters.
- rs_enable is registered: 0 in reset, 1 from the first clock after reset deassertion. The arbiter never stalls the unit.
- Latency L = RSQRT_LATENCY(NUM_ITERATIONS) = 3 + 3*NUM_ITERATIONS, so the default is 9.
  - A result emerges exactly L cycles after rs_data_valid is sampled.
- Eligibility: elig[i] = req_valid[i] & (credit[i] < RESP_DEPTH) & rs_enable.
- Grant is combinational: the first eligible requester scanning from rr_ptr upward, with wrap-around.
  - req_ready = that one-hot grant.
  - rs_data_valid = |grant.
  - rs_data_in = req_data[winner], or 0 when there is no grant.
- rr_ptr updates to winner+1 mod NUM_REQ on a grant and is unchanged otherwise.
- Tag pipe: L-stage shift register of {valid, id[$clog2(NUM_REQ)-1:0]}.
  - Stage 0 is loaded with {rs_data_valid, winner} on every cycle.
  - The tail stage aligns with rs_data_out_valid.
- Tail tag valid and rs_data_out_valid both 1: push {rs_data_out, rs_special} into FIFO[id].
- Tail tag valid and rs_data_out_valid 0: set err_latency. Nothing is pushed, and credit[id] is released (decrement).
- rs_data_out_valid 1 and tail tag valid 0: set err_latency and discard the result.
- credit[i] counts in-flight operations plus buffered entries, range 0..RESP_DEPTH.
  - +1 on grant to i.
  - -1 on the rsp_valid[i] & rsp_ready[i] pop, or on the tag-release error case.
  - Simultaneous +1 and -1 leaves it unchanged.
  - Credit gating guarantees a FIFO push never meets a full FIFO.
- The FIFOs are first-word-fall-through.
  - rsp_valid[i] = !empty.
  - A same-cycle push and pop is legal, at any occupancy including full with pop.
- Per-requester results are returned in issue order. Across requesters, results follow global issue order.
- grant_count increments on each grant.
- credit_stall increments in any cycle where |req_valid & rs_enable and there is no grant, i.e. every valid requester is credit-blocked.
- Both counters wrap at 2^32.
- Reset mid-operation: in-flight tags and FIFO contents are discarded. The unit must share rst_n so that its pipe is also flushed.

Decomposition:
- Package tpu_rsqrt_pkg:
  - function RSQRT_LATENCY(iters) = 3 + 3*iters;
  - typedef rsqrt_rsp_t {logic special; logic [15:0] data};
  - localparam RSQRT_DEFAULT_ITERS = 2.
- Sub-module tpu_rsqrt_resp_fifo: FWFT, parameterised depth, with push, pop, full, empty and count. Instantiated NUM_REQ times.
- Top-level contents: arbiter, tag pipe, credit counters and perf counters.

Test Plan:
- Single requester: req 0 sends 0x0100 (1.0) once → req_ready[0]=1 that cycle. rsp_valid[0] rises exactly 9 cycles later with data from the unit, and grant_count=1.
- All four requesters valid continuously, rsp_ready=all 1 → grants rotate 0,1,2,3,0,… with one grant per cycle. Each rsp stream stays in order, credit_stall=0, and err_latency=0.
- Req 2 valid with rsp_ready[2]=0 → exactly 4 grants, then req_ready[2]=0 and credit_stall increments each cycle. Raising rsp_ready[2] for 1 cycle allows exactly one new grant.
- Input 0x0000 from req 1 → rsp_special[1]=1 and rsp_data[1]=0x7FFF after L cycles.
- Force rs_data_out_valid low at a tag tail → err_latency=1 sticky, and the requester's credit is restored, so a subsequent grant still succeeds.
- Assert rst_n low with 6 operations in flight and FIFOs partly full → all rsp_valid=0, credits=0 and counters=0. The first request after release receives a normal response at L.
